// File: rtl/sokoban_pkg.sv
// rtl/sokoban_pkg.sv - shared Sokoban tile codes, legacy colours and colour widening helper
// Purpose: chunk-type constants used by the map and display paths, the 12-bit
//          legacy colour of each code, and the nibble-replication function that
//          widens a 12-bit colour to an arbitrary channel width.
// Ports:   none (package).
package sokoban_pkg;

  localparam logic [3:0] PLAYER_UP    = 4'd0;
  localparam logic [3:0] PLAYER_DOWN  = 4'd1;
  localparam logic [3:0] PLAYER_LEFT  = 4'd2;
  localparam logic [3:0] PLAYER_RIGHT = 4'd3;
  localparam logic [3:0] BOX          = 4'd4;
  localparam logic [3:0] TARGET       = 4'd5;
  localparam logic [3:0] WALL         = 4'd6;
  localparam logic [3:0] GROUND       = 4'd7;
  localparam logic [3:0] SIDE         = 4'd8;

  function automatic logic [11:0] legacy_color(input logic [3:0] code);
    logic [11:0] c;
    case (code)
      PLAYER_UP:    c = 12'hFFF;
      PLAYER_DOWN:  c = 12'hCCC;
      PLAYER_LEFT:  c = 12'h666;
      PLAYER_RIGHT: c = 12'h000;
      BOX:          c = 12'hF00;
      TARGET:       c = 12'h0F0;
      WALL:         c = 12'h00F;
      GROUND:       c = 12'hFF0;
      SIDE:         c = 12'h222;
      default:      c = 12'h000;
    endcase
    return c;
  endfunction

  // Each nibble is doubled to 8 bits and the top cw bits are kept, so the
  // widened value is packed R,G,B in the low 3*cw bits of the result.
  function automatic logic [23:0] expand_color(input logic [11:0] c, input int cw);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = {c[11:8], c[11:8]} >> (8 - cw);
    g = {c[7:4], c[7:4]} >> (8 - cw);
    b = {c[3:0], c[3:0]} >> (8 - cw);
    return (24'(r) << (2 * cw)) | (24'(g) << cw) | 24'(b);
  endfunction

endpackage

// File: rtl/tile_palette.sv
// rtl/tile_palette.sv - 16-entry colour register file for the tile renderer
// Purpose: writable palette indexed by chunk type, reloaded with the widened
//          legacy colours on reset.
// Ports:   clk, rst (sync, active-high); we/waddr/wdata synchronous write port;
//          raddr/rdata asynchronous read port; ground = fixed tap on GROUND entry.
module tile_palette
  import sokoban_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [3*CW-1:0] wdata,
  input  logic [3:0]      raddr,
  output logic [3*CW-1:0] rdata,
  output logic [3*CW-1:0] ground
);

  logic [3*CW-1:0] mem [16];

  function automatic logic [3*CW-1:0] reset_value(input logic [3:0] idx);
    logic [23:0] full;
    full = expand_color(legacy_color(idx), CW);
    return full[3*CW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= reset_value(4'(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents in the cycle of a write.
  assign rdata  = mem[raddr];
  assign ground = mem[GROUND];

endmodule

// File: rtl/tile_render.sv
// rtl/tile_render.sv - two-stage palette-driven tile pixel renderer
// Purpose: maps chunk type and in-tile pixel position to a colour, adding
//          bevelled wall/box borders, an inset player sprite and (when
//          TILE_RENDER_BLINK_EN is defined) a blinking target marker.
// Ports:   clk, rst (sync, active-high); in_valid, chunk_type, tx, ty pixel
//          request; frame_tick per-frame pulse; pal_we/pal_addr/pal_data
//          palette write; out_valid/dout rendered pixel, 2 cycles after request.
// Macro:   TILE_RENDER_BLINK_EN builds the blink counter and phase.
module tile_render
  import sokoban_pkg::*;
#(
  parameter int CW           = 4,
  parameter int TILE_LOG2    = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           chunk_type,
  input  logic [TILE_LOG2-1:0] tx,
  input  logic [TILE_LOG2-1:0] ty,
  input  logic                 frame_tick,
  input  logic                 pal_we,
  input  logic [3:0]           pal_addr,
  input  logic [3*CW-1:0]      pal_data,
  output logic                 out_valid,
  output logic [3*CW-1:0]      dout
);

  localparam int TILE = 1 << TILE_LOG2;
  localparam logic [TILE_LOG2-1:0] EDGE_MAX = TILE_LOG2'(TILE - 1);
  localparam logic [TILE_LOG2-1:0] MARGIN   = TILE_LOG2'(TILE >> 3);
  localparam logic [TILE_LOG2-1:0] INSET_HI = TILE_LOG2'(TILE - (TILE >> 3));

  logic [3*CW-1:0] pal_rdata;
  logic [3*CW-1:0] pal_ground;

  tile_palette #(.CW(CW)) u_palette (
    .clk    (clk),
    .rst    (rst),
    .we     (pal_we),
    .waddr  (pal_addr),
    .wdata  (pal_data),
    .raddr  (chunk_type),
    .rdata  (pal_rdata),
    .ground (pal_ground)
  );

  logic                 blink_phase;

`ifdef TILE_RENDER_BLINK_EN
  logic [7:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign blink_phase       = 1'b0;
`endif

  // Stage 1: request and both palette reads.
  logic                 s1_valid;
  logic [3:0]           s1_type;
  logic [TILE_LOG2-1:0] s1_tx;
  logic [TILE_LOG2-1:0] s1_ty;
  logic [3*CW-1:0]      s1_color;
  logic [3*CW-1:0]      s1_ground;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_type   <= 4'd0;
      s1_tx     <= '0;
      s1_ty     <= '0;
      s1_color  <= '0;
      s1_ground <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_type   <= chunk_type;
      s1_tx     <= tx;
      s1_ty     <= ty;
      s1_color  <= pal_rdata;
      s1_ground <= pal_ground;
    end
  end

  // Stage 2 colour selection.
  logic            on_border;
  logic            in_margin;
  logic [3*CW-1:0] halved;
  logic [3*CW-1:0] pixel_color;

  assign on_border = (s1_tx == '0) || (s1_tx == EDGE_MAX) ||
                     (s1_ty == '0) || (s1_ty == EDGE_MAX);
  assign in_margin = (s1_tx < MARGIN) || (s1_tx >= INSET_HI) ||
                     (s1_ty < MARGIN) || (s1_ty >= INSET_HI);
  // Per-channel logical shift: the top bit of each channel is cleared so
  // no bit leaks in from the neighbouring channel.
  assign halved = {1'b0, s1_color[3*CW-1:2*CW+1],
                   1'b0, s1_color[2*CW-1:CW+1],
                   1'b0, s1_color[CW-1:1]};

  always_comb begin
    pixel_color = s1_color;
    if ((s1_type == WALL || s1_type == BOX) && on_border) begin
      pixel_color = halved;
    end else if (s1_type <= PLAYER_RIGHT) begin
      pixel_color = in_margin ? s1_ground : s1_color;
    end else if (s1_type == TARGET && blink_phase) begin
      pixel_color = s1_ground;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= pixel_color;
      end
    end
  end

endmodule

// File: tb/tb_tile_render.sv
// tb/tb_tile_render.sv - scoreboard testbench for tile_render
module tb_tile_render;
  localparam int BF = 2;

  localparam logic [11:0] LEG [16] = '{12'hFFF, 12'hCCC, 12'h666, 12'h000,
                                       12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                       12'h222, 12'h000, 12'h000, 12'h000,
                                       12'h000, 12'h000, 12'h000, 12'h000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [3:0]  chunk_type;
  logic [4:0]  tx;
  logic [4:0]  ty;
  logic        frame_tick;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic        out_valid;
  logic [11:0] dout;

  logic        in_valid_b;
  logic [3:0]  chunk_b;
  logic        pal_we_b;
  logic [3:0]  pal_addr_b;
  logic [23:0] pal_data_b;
  logic        out_valid_b;
  logic [23:0] dout_b;

  tile_render #(.CW(4), .TILE_LOG2(5), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .chunk_type(chunk_type),
    .tx(tx), .ty(ty), .frame_tick(frame_tick), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .out_valid(out_valid), .dout(dout)
  );

  tile_render #(.CW(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .chunk_type(chunk_b),
    .tx(tx), .ty(ty), .frame_tick(frame_tick), .pal_we(pal_we_b),
    .pal_addr(pal_addr_b), .pal_data(pal_data_b), .out_valid(out_valid_b), .dout(dout_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] col;
    int          due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [11:0] pal_m [16];
  bit          phase_m;
  int          cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = LEG[i];
    phase_m = 1'b0;
    cnt_m   = 0;
  endtask

  function automatic logic [11:0] model_pix(input logic [3:0] ct, input logic [4:0] x, input logic [4:0] y);
    logic [11:0] c;
    logic [11:0] g;
    logic        border;
    c = pal_m[ct];
    g = pal_m[7];
    border = (x == 0) || (x == 31) || (y == 0) || (y == 31);
    if ((ct == 4 || ct == 6) && border) return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    if (ct <= 3) return (x < 4 || x >= 28 || y < 4 || y >= 28) ? g : c;
    if (ct == 5 && phase_m) return g;
    return c;
  endfunction

  task automatic px(input logic [3:0] ct, input logic [4:0] x, input logic [4:0] y,
                    input bit tick = 0, input bit we = 0,
                    input logic [3:0] wa = 4'd0, input logic [11:0] wd = 12'd0);
    exp_t e;
    in_valid = 1'b1; chunk_type = ct; tx = x; ty = y;
    frame_tick = tick; pal_we = we; pal_addr = wa; pal_data = wd;
`ifdef TILE_RENDER_BLINK_EN
    if (tick) begin
      if (cnt_m == BF - 1) begin
        cnt_m = 0;
        phase_m = ~phase_m;
      end else begin
        cnt_m++;
      end
    end
`endif
    e.col = 24'(model_pix(ct, x, y));
    e.due = cyc + 2;
    qa.push_back(e);
    if (we) pal_m[wa] = wd;
    @(negedge clk);
    in_valid = 1'b0; frame_tick = 1'b0; pal_we = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; frame_tick = 1'b0; pal_we = 1'b0; in_valid_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (out_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_dout", 32'(dout), 32'(e.col));
        chk("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (out_valid_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'(out_valid_b), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_dout", 32'(dout_b), 32'(e.col));
        chk("b_latency", cyc, e.due);
      end
    end
  end

  initial begin
    exp_t eb;
    rst = 1'b1; in_valid = 1'b0; chunk_type = 4'd0; tx = 5'd0; ty = 5'd0;
    frame_tick = 1'b0; pal_we = 1'b0; pal_addr = 4'd0; pal_data = 12'd0;
    in_valid_b = 1'b0; chunk_b = 4'd0; pal_we_b = 1'b0; pal_addr_b = 4'd0; pal_data_b = 24'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    rst = 1'b0;

    px(4'd7, 5'd5, 5'd5);
    idle(3);

    px(4'd6, 5'd0, 5'd7);
    px(4'd6, 5'd3, 5'd3);
    px(4'd6, 5'd31, 5'd10);
    px(4'd4, 5'd0, 5'd0);
    px(4'd4, 5'd12, 5'd31);

    px(4'd2, 5'd2, 5'd16);
    px(4'd2, 5'd16, 5'd16);
    px(4'd2, 5'd28, 5'd16);
    px(4'd2, 5'd27, 5'd16);
    px(4'd2, 5'd16, 5'd3);
    px(4'd2, 5'd16, 5'd4);
    px(4'd0, 5'd10, 5'd10);
    px(4'd3, 5'd16, 5'd27);
    px(4'd1, 5'd4, 5'd4);

    px(4'd4, 5'd5, 5'd5, 1'b0, 1'b1, 4'd4, 12'h0AA);
    px(4'd4, 5'd5, 5'd5);
    px(4'd4, 5'd0, 5'd10);

    px(4'd12, 5'd9, 5'd9);
    px(4'd8, 5'd31, 5'd31);
    px(4'd5, 5'd0, 5'd0);

    for (int i = 0; i < 12; i++) px(4'd5, 5'd8, 5'd8, (i % 2) == 1);
    idle(3);

    in_valid = 1'b1; chunk_type = 4'd4; tx = 5'd5; ty = 5'd5;
    @(negedge clk);
    rst = 1'b1; chunk_type = 4'd6; frame_tick = 1'b1;
    pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'h123;
    in_valid_b = 1'b1; chunk_b = 4'd8;
    @(negedge clk);
    model_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    rst = 1'b0; in_valid = 1'b0; frame_tick = 1'b0; pal_we = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid_1", 32'(out_valid), 32'd0);
    chk("post_rst_dout_1", 32'(dout), 32'd0);
    chk("post_rst_out_valid_b", 32'(out_valid_b), 32'd0);
    @(negedge clk);
    chk("post_rst_out_valid_2", 32'(out_valid), 32'd0);
    chk("post_rst_dout_2", 32'(dout), 32'd0);

    px(4'd4, 5'd5, 5'd5);
    px(4'd5, 5'd5, 5'd5);
    px(4'd5, 5'd5, 5'd5, 1'b1);
    px(4'd5, 5'd5, 5'd5, 1'b1);
    px(4'd5, 5'd5, 5'd5);

    in_valid_b = 1'b1; chunk_b = 4'd8; tx = 5'd10; ty = 5'd10;
    eb.col = 24'h222222;
    eb.due = cyc + 2;
    qb.push_back(eb);
    @(negedge clk);
    in_valid_b = 1'b0;
    idle(5);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
